// File: rtl/mem_stage.sv
// Memory-access stage of the 16-bit core.
// Executes loads, stores, PUSH/POP and the multi-word PC/flag stack sequences
// used by CALL/INT/RET/RTI. Owns the stack pointer and the data memory, and
// registers results toward the MEM/WB stage.
module mem_stage #(
    parameter int unsigned WbSize   = 2,
    parameter int unsigned MemSize  = 6,
    parameter int unsigned flagSize = 4,
    parameter int unsigned AddrW    = 12,
    parameter int unsigned SpInit   = 2**AddrW - 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MemSize-1:0]  i_Mem,
    input  logic [WbSize-1:0]   i_WB,
    input  logic [31:0]         i_pc,
    input  logic [2:0]          i_Rdst,
    input  logic [15:0]         i_alu,
    input  logic [15:0]         i_read_data1,
    input  logic [flagSize-1:0] i_flag,
    output logic [WbSize-1:0]   o_WB,
    output logic [2:0]          o_Rdst,
    output logic [15:0]         o_alu,
    output logic [15:0]         o_mem_data,
    output logic                o_stall,
    output logic [31:0]         o_pc_ret,
    output logic                o_pc_valid,
    output logic [flagSize-1:0] o_flag_rest,
    output logic                o_flag_valid,
    output logic [AddrW-1:0]    o_sp
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] W1   = 2'd1;
    localparam logic [1:0] W2   = 2'd2;
    localparam logic [1:0] W3   = 2'd3;

    localparam logic [AddrW-1:0] SP_RESET = AddrW'(SpInit);

    logic [15:0] mem [0:2**AddrW-1];

    logic [1:0]          state_q;
    logic [AddrW-1:0]    sp_q;
    logic [AddrW-1:0]    sp_inc;
    logic [AddrW-1:0]    sp_dec;

    // Values captured when a stack sequence starts
    logic [31:0]         pc_lat;
    logic [flagSize-1:0] flag_lat;
    logic [WbSize-1:0]   wb_lat;
    logic [2:0]          rdst_lat;
    logic [15:0]         alu_lat;
    logic                seq_pop_q;
    logic                seq_flag_q;
    logic [15:0]         lo_q;
    logic [flagSize-1:0] rflag_q;

    logic                mem_rd;
    logic                mem_wr;
    logic                mem_push;
    logic                mem_pop;
    logic                mem_pc_op;
    logic                mem_flag_op;

    logic                we_raw;
    logic                mem_we;
    logic [AddrW-1:0]    waddr;
    logic [15:0]         wdata;
    logic [AddrW-1:0]    raddr;
    logic [15:0]         rdata;

    logic                unused_bits;

    assign mem_rd      = i_Mem[0];
    assign mem_wr      = i_Mem[1];
    assign mem_push    = i_Mem[2];
    assign mem_pop     = i_Mem[3];
    assign mem_pc_op   = i_Mem[4];
    assign mem_flag_op = i_Mem[5];

    assign sp_inc = sp_q + AddrW'(1);
    assign sp_dec = sp_q - AddrW'(1);
    assign o_sp   = sp_q;
    assign rdata  = mem[raddr];
    assign mem_we = we_raw & rst;

    assign unused_bits = ^{i_alu, i_Mem};

    // Memory port selection and upstream stall for the current state
    always_comb begin
        we_raw  = 1'b0;
        waddr   = sp_q;
        wdata   = i_read_data1;
        raddr   = sp_inc;
        o_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_push) begin
                    we_raw  = 1'b1;
                    wdata   = mem_pc_op ? i_pc[31:16] : i_read_data1;
                    o_stall = mem_pc_op;
                end else if (mem_pop) begin
                    o_stall = mem_pc_op;
                end else begin
                    raddr = i_alu[AddrW-1:0];
                    if (mem_wr) begin
                        we_raw = 1'b1;
                        waddr  = i_alu[AddrW-1:0];
                    end
                end
            end
            W1: begin
                o_stall = seq_flag_q;
                if (!seq_pop_q) begin
                    we_raw = 1'b1;
                    wdata  = pc_lat[15:0];
                end
            end
            W2: begin
                if (!seq_pop_q) begin
                    we_raw = 1'b1;
                    wdata  = 16'(flag_lat);
                end
            end
            default: ;
        endcase
    end

    // Data memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[waddr] <= wdata;
        end
    end

    // FSM, stack pointer and registered results toward MEM/WB
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            sp_q         <= SP_RESET;
            pc_lat       <= '0;
            flag_lat     <= '0;
            wb_lat       <= '0;
            rdst_lat     <= '0;
            alu_lat      <= '0;
            seq_pop_q    <= 1'b0;
            seq_flag_q   <= 1'b0;
            lo_q         <= '0;
            rflag_q      <= '0;
            o_WB         <= '0;
            o_Rdst       <= '0;
            o_alu        <= '0;
            o_mem_data   <= '0;
            o_pc_ret     <= '0;
            o_pc_valid   <= 1'b0;
            o_flag_rest  <= '0;
            o_flag_valid <= 1'b0;
        end else begin
            o_pc_valid   <= 1'b0;
            o_flag_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_pc_op && (mem_push || mem_pop)) begin
                        pc_lat     <= i_pc;
                        flag_lat   <= i_flag;
                        wb_lat     <= i_WB;
                        rdst_lat   <= i_Rdst;
                        alu_lat    <= i_alu;
                        seq_pop_q  <= !mem_push;
                        seq_flag_q <= mem_flag_op;
                        o_WB       <= '0;
                        o_mem_data <= '0;
                        state_q    <= W1;
                        if (mem_push) begin
                            sp_q <= sp_dec;
                        end else begin
                            sp_q <= sp_inc;
                            // RTI pops the flags word first, RET pops the low PC word
                            if (mem_flag_op) begin
                                rflag_q <= rdata[flagSize-1:0];
                            end else begin
                                lo_q <= rdata;
                            end
                        end
                    end else begin
                        o_WB   <= i_WB;
                        o_Rdst <= i_Rdst;
                        o_alu  <= i_alu;
                        if (mem_push) begin
                            sp_q       <= sp_dec;
                            o_mem_data <= '0;
                        end else if (mem_pop) begin
                            sp_q       <= sp_inc;
                            o_mem_data <= rdata;
                        end else begin
                            o_mem_data <= mem_rd ? rdata : '0;
                        end
                    end
                end
                W1: begin
                    o_mem_data <= '0;
                    if (!seq_pop_q) begin
                        sp_q <= sp_dec;
                    end else begin
                        sp_q <= sp_inc;
                    end
                    if (seq_flag_q) begin
                        o_WB    <= '0;
                        state_q <= W2;
                        if (seq_pop_q) begin
                            lo_q <= rdata;
                        end
                    end else begin
                        o_WB    <= wb_lat;
                        o_Rdst  <= rdst_lat;
                        o_alu   <= alu_lat;
                        state_q <= IDLE;
                        if (seq_pop_q) begin
                            o_pc_ret   <= {rdata, lo_q};
                            o_pc_valid <= 1'b1;
                        end
                    end
                end
                W2: begin
                    o_mem_data <= '0;
                    o_WB       <= wb_lat;
                    o_Rdst     <= rdst_lat;
                    o_alu      <= alu_lat;
                    state_q    <= IDLE;
                    if (!seq_pop_q) begin
                        sp_q <= sp_dec;
                    end else begin
                        sp_q         <= sp_inc;
                        o_pc_ret     <= {rdata, lo_q};
                        o_pc_valid   <= 1'b1;
                        o_flag_rest  <= rflag_q;
                        o_flag_valid <= 1'b1;
                    end
                end
                default: begin
                    o_WB       <= '0;
                    o_mem_data <= '0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: reset, load/store, push/pop, CALL/RET,
// INT/RTI and stack-pointer wrap, with hand-computed expectations.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  i_Mem;
    logic [1:0]  i_WB;
    logic [31:0] i_pc;
    logic [2:0]  i_Rdst;
    logic [15:0] i_alu;
    logic [15:0] i_read_data1;
    logic [3:0]  i_flag;
    logic [1:0]  o_WB;
    logic [2:0]  o_Rdst;
    logic [15:0] o_alu;
    logic [15:0] o_mem_data;
    logic        o_stall;
    logic [31:0] o_pc_ret;
    logic        o_pc_valid;
    logic [3:0]  o_flag_rest;
    logic        o_flag_valid;
    logic [11:0] o_sp;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(
        .WbSize(2),
        .MemSize(6),
        .flagSize(4),
        .AddrW(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_Mem(i_Mem),
        .i_WB(i_WB),
        .i_pc(i_pc),
        .i_Rdst(i_Rdst),
        .i_alu(i_alu),
        .i_read_data1(i_read_data1),
        .i_flag(i_flag),
        .o_WB(o_WB),
        .o_Rdst(o_Rdst),
        .o_alu(o_alu),
        .o_mem_data(o_mem_data),
        .o_stall(o_stall),
        .o_pc_ret(o_pc_ret),
        .o_pc_valid(o_pc_valid),
        .o_flag_rest(o_flag_rest),
        .o_flag_valid(o_flag_valid),
        .o_sp(o_sp)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    localparam logic [5:0] OP_NONE = 6'b000000;
    localparam logic [5:0] OP_RD   = 6'b000001;
    localparam logic [5:0] OP_WR   = 6'b000010;
    localparam logic [5:0] OP_RDWR = 6'b000011;
    localparam logic [5:0] OP_PUSH = 6'b000100;
    localparam logic [5:0] OP_POP  = 6'b001000;
    localparam logic [5:0] OP_CALL = 6'b010100;
    localparam logic [5:0] OP_RET  = 6'b011000;
    localparam logic [5:0] OP_INT  = 6'b110100;
    localparam logic [5:0] OP_RTI  = 6'b111000;

    initial begin
        rst          = 1'b0;
        i_Mem        = OP_NONE;
        i_WB         = '0;
        i_pc         = '0;
        i_Rdst       = '0;
        i_alu        = '0;
        i_read_data1 = '0;
        i_flag       = '0;

        // T1 reset
        step();
        step();
        chk("rst_sp", o_sp, 32'hFFF);
        chk("rst_wb", o_WB, 0);
        chk("rst_rdst", o_Rdst, 0);
        chk("rst_alu", o_alu, 0);
        chk("rst_mdata", o_mem_data, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_pcret", o_pc_ret, 0);
        chk("rst_pcv", o_pc_valid, 0);
        chk("rst_flag", o_flag_rest, 0);
        chk("rst_flagv", o_flag_valid, 0);
        rst = 1'b1;

        // T2 store then load, plus simultaneous rd+wr
        i_Mem = OP_WR; i_alu = 16'h0010; i_read_data1 = 16'hBEEF; i_WB = 2'b01; i_Rdst = 3'd3;
        chk("wr_stall", o_stall, 0);
        step();
        chk("wr_wb", o_WB, 2'b01);
        chk("wr_rdst", o_Rdst, 3);
        chk("wr_alu", o_alu, 32'h0010);
        chk("wr_mdata", o_mem_data, 0);
        i_Mem = OP_RD; i_WB = 2'b00;
        step();
        chk("rd_mdata", o_mem_data, 32'hBEEF);
        i_Mem = OP_RDWR; i_read_data1 = 16'hCAFE;
        step();
        chk("rdwr_old", o_mem_data, 32'hBEEF);
        i_Mem = OP_RD;
        step();
        chk("rd_new", o_mem_data, 32'hCAFE);
        i_Mem = OP_NONE;
        step();
        chk("none_mdata", o_mem_data, 0);

        // T3 push/push/pop/pop
        i_Mem = OP_PUSH; i_read_data1 = 16'h1234;
        step();
        chk("push1_sp", o_sp, 32'hFFE);
        i_read_data1 = 16'h5678;
        step();
        chk("push2_sp", o_sp, 32'hFFD);
        i_Mem = OP_POP;
        step();
        chk("pop1_data", o_mem_data, 32'h5678);
        chk("pop1_sp", o_sp, 32'hFFE);
        step();
        chk("pop2_data", o_mem_data, 32'h1234);
        chk("pop2_sp", o_sp, 32'hFFF);

        // T4 CALL then RET
        i_Mem = OP_CALL; i_pc = 32'h0001_00A0; i_WB = 2'b10; i_Rdst = 3'd5; i_alu = 16'h0077;
        #1;
        chk("call_stall0", o_stall, 1);
        step();
        chk("call_stall1", o_stall, 0);
        chk("call_bubble", o_WB, 0);
        chk("call_sp1", o_sp, 32'hFFE);
        step();
        chk("call_wb", o_WB, 2'b10);
        chk("call_rdst", o_Rdst, 5);
        chk("call_alu", o_alu, 32'h0077);
        chk("call_sp2", o_sp, 32'hFFD);
        i_Mem = OP_RET; i_pc = '0; i_WB = 2'b00;
        #1;
        chk("ret_stall0", o_stall, 1);
        step();
        chk("ret_stall1", o_stall, 0);
        chk("ret_pcv0", o_pc_valid, 0);
        chk("ret_sp1", o_sp, 32'hFFE);
        step();
        chk("ret_pc", o_pc_ret, 32'h0001_00A0);
        chk("ret_pcv", o_pc_valid, 1);
        chk("ret_flagv", o_flag_valid, 0);
        chk("ret_sp2", o_sp, 32'hFFF);
        i_Mem = OP_NONE;
        step();
        chk("ret_pulse", o_pc_valid, 0);

        // T5 INT then RTI
        i_Mem = OP_INT; i_pc = 32'h0000_0200; i_flag = 4'b1010;
        #1;
        chk("int_stall0", o_stall, 1);
        step();
        chk("int_stall1", o_stall, 1);
        chk("int_sp1", o_sp, 32'hFFE);
        step();
        chk("int_stall2", o_stall, 0);
        chk("int_sp2", o_sp, 32'hFFD);
        step();
        chk("int_sp3", o_sp, 32'hFFC);
        i_Mem = OP_RTI; i_pc = '0; i_flag = '0;
        #1;
        chk("rti_stall0", o_stall, 1);
        step();
        chk("rti_stall1", o_stall, 1);
        step();
        chk("rti_stall2", o_stall, 0);
        chk("rti_pcv0", o_pc_valid, 0);
        step();
        chk("rti_pc", o_pc_ret, 32'h0000_0200);
        chk("rti_pcv", o_pc_valid, 1);
        chk("rti_flag", o_flag_rest, 4'b1010);
        chk("rti_flagv", o_flag_valid, 1);
        chk("rti_sp", o_sp, 32'hFFF);
        i_Mem = OP_NONE;
        step();
        chk("rti_pulse", o_flag_valid, 0);
        chk("rti_hold", o_flag_rest, 4'b1010);

        // T6 SP wrap both ways
        i_Mem = OP_PUSH; i_read_data1 = 16'h0101;
        repeat (4095) step();
        chk("wrap_sp0", o_sp, 0);
        i_read_data1 = 16'hAAAA;
        step();
        chk("wrap_push", o_sp, 32'hFFF);
        i_Mem = OP_POP;
        step();
        chk("wrap_pop_sp", o_sp, 0);
        chk("wrap_pop_data", o_mem_data, 32'hAAAA);

        // T6 reset during W1 of CALL
        i_Mem = OP_NONE; rst = 1'b0;
        step();
        rst = 1'b1;
        i_Mem = OP_CALL; i_pc = 32'h1234_5678;
        step();
        chk("abort_sp_w1", o_sp, 32'hFFE);
        rst = 1'b0; i_Mem = OP_NONE;
        step();
        chk("abort_sp", o_sp, 32'hFFF);
        chk("abort_stall", o_stall, 0);
        chk("abort_pcv", o_pc_valid, 0);
        rst = 1'b1;
        step();
        chk("abort_idle_sp", o_sp, 32'hFFF);
        chk("abort_idle_pcv", o_pc_valid, 0);
        i_Mem = OP_PUSH; i_read_data1 = 16'h0042;
        step();
        chk("abort_push_sp", o_sp, 32'hFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
